mips_data_mem: RTL and testbench
================================

// Module: mips_data_mem
// PURPOSE
//  Data-memory responder for the single-cycle MIPS core. Answers the core's load/store port
//  (address, write data, write strobe) with same-cycle read data.
//  Holds a word-addressed RAM plus a small MMIO window: GPIO out/in and a down-counting timer.
//  Instantiated beside the core at SoC top; its ReadData feeds the core's ReadData input.
// PARAMETERS
//  width      32            data/address width
//  RAM_WORDS  256           RAM depth in words (power of 2); RAM spans byte addr 0 .. 4*RAM_WORDS-1
//  MMIO_BASE  32'hFFFF_0000 byte base of the register window (5 words)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  ALUOut     in   width  byte address from the core
//  WriteData  in   width  store data
//  MemWrite   in   1      store strobe, sampled at rising clk
//  ReadData   out  width  load data, combinational from ALUOut
//  gpio_in    in   width  external asynchronous inputs
//  gpio_out   out  width  GPIO_OUT register
//  timer_irq  out  1      level = TIMER_CTRL.expired & TIMER_CTRL.irq_en
//  bus_err    out  1      one-cycle pulse, cycle after an illegal store
// BEHAVIOUR
//  Decode: RAM if ALUOut < 4*RAM_WORDS; MMIO if ALUOut in MMIO_BASE+0x00..0x10; otherwise unmapped.
//  Word index = ALUOut[log2(RAM_WORDS)+1:2]. Misaligned = ALUOut[1:0] != 0.
//  Read: combinational, zero latency. Misaligned or unmapped -> 0. Reads have no side effects.
//  Write: on rising clk when MemWrite=1. Takes effect that edge; a load next cycle sees new data.
//  Misaligned or unmapped store: ignored, bus_err=1 for exactly the next cycle.
//  RAM contents are not reset (undefined until written).
//  MMIO map (offset from MMIO_BASE):
//   0x00 GPIO_OUT     R/W, full word.
//   0x04 GPIO_IN      RO; 2-flop synchronised gpio_in. Store ignored, no bus_err.
//   0x08 TIMER_CNT    R/W current count.
//   0x0C TIMER_CTRL   bit0 en, bit1 autoreload, bit2 expired (sticky, W1C), bit3 irq_en. Other bits read 0.
//   0x10 TIMER_RELOAD R/W reload value.
//  Timer, per cycle when en=1 and CNT!=0:
//   - CNT decrements by 1.
//   - If CNT==1: expired<=1; CNT<=RELOAD if autoreload, else 0.
//   - en=1 with CNT==0: count holds, no expiry.
//  Precedence:
//   - Store to TIMER_CNT beats that cycle's decrement/reload.
//   - Expiry set beats a same-cycle W1C of expired.
//   - Store to TIMER_CTRL updates en/autoreload/irq_en; bit2=1 clears expired.
//  Reset (async, rst_n=0):
//   - gpio_out, CNT, RELOAD, CTRL and sync flops -> 0; bus_err=0; timer_irq=0.
//   - ReadData still follows the decode; MMIO reads give reset values.
//   - Reset mid-count aborts the count; no expiry is generated.
// TESTING
//  1 Store 0xDEADBEEF @0x10, load 0x10 next cycle -> ReadData=0xDEADBEEF; load 0x14 unwritten -> no X on MMIO/zero paths.
//  2 Store @0x12 (misaligned) and @0x0001_0000 (unmapped) -> bus_err 1-cycle pulse each; RAM word 0x10 unchanged; loads return 0.
//  3 GPIO: store 0xA5 @BASE+0 -> gpio_out=0xA5 next cycle; gpio_in=0x3C -> load BASE+4 =0x3C from 2nd edge on, 0 before.
//  4 CNT=3, RELOAD=5, CTRL=0xB (en|auto|irq) -> CNT 2,1,5,4..; expired and timer_irq rise on the 1->5 edge; W1C CTRL=0xF clears them.
//  5 Non-auto CNT=2, en -> 1, 0, then holds 0; expired=1. Store CNT=7 on the expiry edge -> CNT=7.
//  6 Assert rst_n low mid-count -> CNT, CTRL, gpio_out, timer_irq all 0 immediately; RAM data survives.

Source files
------------

// File: rtl/mips_data_mem.sv
// Data memory for the single-cycle MIPS core: word RAM plus MMIO window.
// Ports: clk, rst_n, ALUOut/WriteData/MemWrite -> ReadData, gpio_in/out, timer_irq, bus_err.
module mips_data_mem #(
  parameter int unsigned width     = 32,
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] ALUOut,
  input  logic [width-1:0] WriteData,
  input  logic             MemWrite,
  output logic [width-1:0] ReadData,
  input  logic [width-1:0] gpio_in,
  output logic [width-1:0] gpio_out,
  output logic             timer_irq,
  output logic             bus_err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam logic [width-1:0] RAM_BYTES = width'(4 * RAM_WORDS);
  localparam logic [width-1:0] MMIO_SPAN = width'(20);

  logic [width-1:0] r_mem [RAM_WORDS];

  logic [width-1:0] r_gpio_out;
  logic [width-1:0] r_sync1;
  logic [width-1:0] r_sync2;
  logic [width-1:0] r_cnt;
  logic [width-1:0] r_reload;
  logic             r_en;
  logic             r_auto;
  logic             r_expired;
  logic             r_irq_en;
  logic             r_bus_err;

  logic             w_mis;
  logic             w_ram_hit;
  logic             w_mmio_hit;
  logic [width-1:0] w_mmio_off;
  logic [2:0]       w_reg;
  logic [AW-1:0]    w_idx;
  logic             w_ram_acc;
  logic             w_mmio_acc;
  logic             w_ram_st;
  logic             w_mmio_st;
  logic             w_st_gpio;
  logic             w_st_cnt;
  logic             w_st_ctrl;
  logic             w_st_rel;
  logic             w_st_bad;
  logic [width-1:0] w_rdata;
  logic [width-1:0] w_ctrl;
  logic [width-1:0] w_cnt_nxt;
  logic             w_exp_nxt;
  logic             w_expire;

  assign w_mis      = |ALUOut[1:0];
  assign w_ram_hit  = ALUOut < RAM_BYTES;
  assign w_mmio_off = ALUOut - MMIO_BASE;
  assign w_mmio_hit = w_mmio_off < MMIO_SPAN;
  assign w_reg      = w_mmio_off[4:2];
  assign w_idx      = ALUOut[AW+1:2];
  assign w_ram_acc  = w_ram_hit & ~w_mis;
  assign w_mmio_acc = w_mmio_hit & ~w_mis;

  assign w_ram_st  = MemWrite & w_ram_acc;
  assign w_mmio_st = MemWrite & w_mmio_acc;
  assign w_st_gpio = w_mmio_st & (w_reg == 3'd0);
  assign w_st_cnt  = w_mmio_st & (w_reg == 3'd2);
  assign w_st_ctrl = w_mmio_st & (w_reg == 3'd3);
  assign w_st_rel  = w_mmio_st & (w_reg == 3'd4);
  assign w_st_bad  = MemWrite & ~w_ram_acc & ~w_mmio_acc;

  assign w_ctrl = {{(width-4){1'b0}}, r_irq_en, r_expired, r_auto, r_en};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_ram_acc: w_rdata = r_mem[w_idx];
      w_mmio_acc: begin
        case (w_reg)
          3'd0:    w_rdata = r_gpio_out;
          3'd1:    w_rdata = r_sync2;
          3'd2:    w_rdata = r_cnt;
          3'd3:    w_rdata = w_ctrl;
          3'd4:    w_rdata = r_reload;
          default: w_rdata = '0;
        endcase
      end
      default: w_rdata = '0;
    endcase
  end

  // Timer next state; a CNT store overrides the tick, and an expiry
  // outranks a same-cycle write-one-to-clear.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_expire  = 1'b0;
    if (r_en && r_cnt != '0) begin
      if (r_cnt == width'(1)) begin
        w_expire  = 1'b1;
        w_cnt_nxt = r_auto ? r_reload : '0;
      end else begin
        w_cnt_nxt = r_cnt - width'(1);
      end
    end
    if (w_st_cnt) w_cnt_nxt = WriteData;
    w_exp_nxt = r_expired;
    if (w_st_ctrl && WriteData[2]) w_exp_nxt = 1'b0;
    if (w_expire) w_exp_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_ram_st) r_mem[w_idx] <= WriteData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cnt      <= '0;
      r_reload   <= '0;
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_expired  <= 1'b0;
      r_irq_en   <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_sync1   <= gpio_in;
      r_sync2   <= r_sync1;
      r_cnt     <= w_cnt_nxt;
      r_expired <= w_exp_nxt;
      r_bus_err <= w_st_bad;
      if (w_st_gpio) r_gpio_out <= WriteData;
      if (w_st_rel)  r_reload   <= WriteData;
      if (w_st_ctrl) begin
        r_en     <= WriteData[0];
        r_auto   <= WriteData[1];
        r_irq_en <= WriteData[3];
      end
    end
  end

  assign ReadData  = w_rdata;
  assign gpio_out  = r_gpio_out;
  assign timer_irq = r_expired & r_irq_en;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed self-checking bench for mips_data_mem.
// One task per feature, each with its own inline checks.
module tb_mips_data_mem;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ALUOut = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mips_data_mem dut (
    .clk(clk), .rst_n(rst_n), .ALUOut(ALUOut),
    .WriteData(WriteData), .MemWrite(MemWrite),
    .ReadData(ReadData), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .timer_irq(timer_irq),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ALUOut = a;
    WriteData = d;
    MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ALUOut = a;
    #1;
    d = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2;
    n_checks++;
    if (gpio_out !== 32'h0 || bus_err !== 1'b0 || timer_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outs: gpio=%h berr=%b irq=%b want 0/0/0", gpio_out, bus_err, timer_irq);
    end
    rd(B + 32'h8, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %h want 0", d);
    end
    rd(B + 32'hC, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %h want 0", d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, d);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL ram_rd: got %h want deadbeef", d);
    end
    rd(B + 32'h14, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL mmio_hole: got %h want 0", d);
    end
    rd(32'h0002_0000, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL unmapped_rd: got %h want 0", d);
    end
  endtask

  task automatic test_bus_err();
    logic [31:0] d;
    wr(32'h12, 32'h1111_1111);
    n_checks++;
    if (bus_err !== 1'b1) begin
      n_errors++;
      $display("FAIL berr_mis_hi: got %b want 1", bus_err);
    end
    step();
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_errors++;
      $display("FAIL berr_mis_lo: got %b want 0", bus_err);
    end
    wr(32'h0001_0000, 32'h2222_2222);
    n_checks++;
    if (bus_err !== 1'b1) begin
      n_errors++;
      $display("FAIL berr_unm_hi: got %b want 1", bus_err);
    end
    step();
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_errors++;
      $display("FAIL berr_unm_lo: got %b want 0", bus_err);
    end
    rd(32'h10, d);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL ram_kept: got %h want deadbeef", d);
    end
    rd(32'h12, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL mis_rd: got %h want 0", d);
    end
    rd(32'h0001_0000, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL unm_rd: got %h want 0", d);
    end
    wr(B + 32'h4, 32'hFFFF_FFFF);
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_errors++;
      $display("FAIL berr_gpio_in: got %b want 0", bus_err);
    end
  endtask

  task automatic test_gpio();
    logic [31:0] d;
    wr(B, 32'hA5);
    n_checks++;
    if (gpio_out !== 32'hA5) begin
      n_errors++;
      $display("FAIL gpio_out: got %h want a5", gpio_out);
    end
    rd(B, d);
    n_checks++;
    if (d !== 32'hA5) begin
      n_errors++;
      $display("FAIL gpio_out_rd: got %h want a5", d);
    end
    gpio_in = 32'h3C;
    rd(B + 32'h4, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL gpio_in_e0: got %h want 0", d);
    end
    step();
    rd(B + 32'h4, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL gpio_in_e1: got %h want 0", d);
    end
    step();
    rd(B + 32'h4, d);
    n_checks++;
    if (d !== 32'h3C) begin
      n_errors++;
      $display("FAIL gpio_in_e2: got %h want 3c", d);
    end
  endtask

  task automatic test_timer_auto();
    logic [31:0] d;
    logic [31:0] exp_cnt [4] = '{32'd2, 32'd1, 32'd5, 32'd4};
    logic        exp_irq [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    wr(B + 32'h8, 32'd3);
    wr(B + 32'h10, 32'd5);
    wr(B + 32'hC, 32'hB);
    rd(B + 32'h8, d);
    n_checks++;
    if (d !== 32'd3) begin
      n_errors++;
      $display("FAIL auto_start: got %0d want 3", d);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      rd(B + 32'h8, d);
      n_checks++;
      if (d !== exp_cnt[i] || timer_irq !== exp_irq[i]) begin
        n_errors++;
        $display("FAIL auto_tick%0d: cnt=%0d irq=%b want %0d/%b", i, d, timer_irq, exp_cnt[i], exp_irq[i]);
      end
    end
    wr(B + 32'hC, 32'hF);
    rd(B + 32'hC, d);
    n_checks++;
    if (d !== 32'hB || timer_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL auto_w1c: ctrl=%h irq=%b want b/0", d, timer_irq);
    end
    rd(B + 32'h8, d);
    n_checks++;
    if (d !== 32'd3) begin
      n_errors++;
      $display("FAIL auto_after: got %0d want 3", d);
    end
  endtask

  task automatic test_timer_oneshot();
    logic [31:0] d;
    wr(B + 32'hC, 32'h4);
    wr(B + 32'h8, 32'd2);
    wr(B + 32'hC, 32'h1);
    step();
    rd(B + 32'h8, d);
    n_checks++;
    if (d !== 32'd1) begin
      n_errors++;
      $display("FAIL one_cnt1: got %0d want 1", d);
    end
    step();
    rd(B + 32'hC, d);
    n_checks++;
    if (d !== 32'h5) begin
      n_errors++;
      $display("FAIL one_ctrl: got %h want 5", d);
    end
    step();
    step();
    rd(B + 32'h8, d);
    n_checks++;
    if (d !== 32'd0 || timer_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL one_hold: cnt=%0d irq=%b want 0/0", d, timer_irq);
    end
    wr(B + 32'h8, 32'd2);
    step();
    wr(B + 32'h8, 32'd7);
    rd(B + 32'h8, d);
    n_checks++;
    if (d !== 32'd7) begin
      n_errors++;
      $display("FAIL one_store_wins: got %0d want 7", d);
    end
  endtask

  task automatic test_precedence();
    logic [31:0] d;
    wr(B + 32'hC, 32'h4);
    wr(B + 32'h8, 32'd1);
    wr(B + 32'hC, 32'h9);
    wr(B + 32'hC, 32'hD);
    rd(B + 32'hC, d);
    n_checks++;
    if (d !== 32'hD || timer_irq !== 1'b1) begin
      n_errors++;
      $display("FAIL prec_exp_w1c: ctrl=%h irq=%b want d/1", d, timer_irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(B, 32'h55);
    wr(B + 32'h8, 32'd100);
    step();
    rd(B + 32'h8, d);
    n_checks++;
    if (d !== 32'd99 || timer_irq !== 1'b1 || gpio_out !== 32'h55) begin
      n_errors++;
      $display("FAIL pre_rst: cnt=%0d irq=%b gpio=%h want 99/1/55", d, timer_irq, gpio_out);
    end
    #2;
    rst_n = 1'b0;
    rd(B + 32'h8, d);
    n_checks++;
    if (d !== 32'd0 || timer_irq !== 1'b0 || gpio_out !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_mid: cnt=%0d irq=%b gpio=%h want 0/0/0", d, timer_irq, gpio_out);
    end
    rd(B + 32'hC, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_ctrl: got %h want 0", d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd(32'h10, d);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL rst_ram: got %h want deadbeef", d);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_bus_err();
    test_gpio();
    test_timer_auto();
    test_timer_oneshot();
    test_precedence();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
